// File: rtl/axil_master_bridge_if.sv
// AXI4-Lite channel bundle between the bridge (master) and a register slave.
interface axil_master_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) ();
  logic              M_AXI_AWVALID, M_AXI_AWREADY;
  logic [ADDR_W-1:0] M_AXI_AWADDR;
  logic [2:0]        M_AXI_AWPROT;
  logic              M_AXI_WVALID, M_AXI_WREADY;
  logic [DATA_W-1:0] M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic              M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_ARVALID, M_AXI_ARREADY;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_RVALID, M_AXI_RREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;

  modport master (
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );
endinterface

// File: rtl/axil_master_bridge.sv
// Single-outstanding bridge from a local cmd/rsp stream to AXI4-Lite master channels.
// Every AXI output is a register, so no VALID ever depends combinationally on a READY.
module axil_master_bridge #(
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int OPT_READ_FIRST     = 0
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  axil_master_bridge_if.master            m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  if (DW != 32 && DW != 64) begin : g_bad_dw
    $error("C_M_AXI_DATA_WIDTH must be 32 or 64");
  end
  // Priority option is reserved: with one transaction in flight there is nothing to order.
  if (OPT_READ_FIRST != 0 && OPT_READ_FIRST != 1) begin : g_bad_opt
    $error("OPT_READ_FIRST must be 0 or 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_RSP} state_e;

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: if (cmd_valid && cmd_ready_q) begin
        addr_d   = cmd_addr;
        rsp_we_d = cmd_we;
        if (cmd_we) begin
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WRITE;
        end else begin
          arvalid_d = 1'b1;
          state_d   = S_READ;
        end
      end
      S_WRITE: begin
        // AW and W retire independently; B is only accepted once both have.
        awvalid_d = awvalid_q && !m_axi.M_AXI_AWREADY;
        wvalid_d  = wvalid_q && !m_axi.M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: if (m_axi.M_AXI_BVALID) begin
        rsp_resp_d  = m_axi.M_AXI_BRESP;
        rsp_rdata_d = '0;
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_READ: if (m_axi.M_AXI_ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = S_RDATA;
      end
      S_RDATA: if (m_axi.M_AXI_RVALID) begin
        rsp_resp_d  = m_axi.M_AXI_RRESP;
        rsp_rdata_d = m_axi.M_AXI_RDATA;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready: a new command is taken no earlier than the cycle after the rsp handshake.
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_ARADDR  = addr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: register-file slave with tunable ready delays and a response scoreboard.
module tb_axil_master_bridge;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int NW = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;

  axil_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  axil_master_bridge #(
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .OPT_READ_FIRST(0)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi(axi)
  );

  int errs = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 17) ? 32'hCAFE_0044 : '0;
  endfunction

  // ---------------- slave ----------------
  int         aw_wait = 0, w_wait = 0, ar_wait = 0;
  logic [1:0] cfg_bresp = 2'b00;

  logic [DW-1:0] mem [NW];
  int            aw_cnt, w_cnt, ar_cnt;
  logic          aw_have, w_have, bvalid, rvalid;
  logic [AW-1:0] aw_addr_l;
  logic [DW-1:0] w_data_l, rdata;
  logic [SW-1:0] w_strb_l;
  logic [1:0]    bresp;
  logic          aw_hs, w_hs, ar_hs, aw_full, w_full;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [SW-1:0] ws;

  assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && !aw_have && (aw_cnt >= aw_wait);
  assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID && !w_have && (w_cnt >= w_wait);
  assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && !rvalid && (ar_cnt >= ar_wait);
  assign axi.M_AXI_BVALID  = bvalid;
  assign axi.M_AXI_BRESP   = bresp;
  assign axi.M_AXI_RVALID  = rvalid;
  assign axi.M_AXI_RDATA   = rdata;
  assign axi.M_AXI_RRESP   = 2'b00;
  assign aw_hs = axi.M_AXI_AWVALID && axi.M_AXI_AWREADY;
  assign w_hs  = axi.M_AXI_WVALID && axi.M_AXI_WREADY;
  assign ar_hs = axi.M_AXI_ARVALID && axi.M_AXI_ARREADY;

  always_comb begin
    aw_full = aw_have || aw_hs;
    w_full  = w_have || w_hs;
    wa = aw_have ? aw_addr_l : axi.M_AXI_AWADDR;
    wd = w_have ? w_data_l : axi.M_AXI_WDATA;
    ws = w_have ? w_strb_l : axi.M_AXI_WSTRB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_have <= 1'b0; w_have <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0; bresp <= '0; rdata <= '0;
      for (int i = 0; i < NW; i++) mem[i] <= init_val(i);
    end else begin
      aw_cnt <= (axi.M_AXI_AWVALID && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.M_AXI_WVALID && !w_hs) ? w_cnt + 1 : 0;
      ar_cnt <= (axi.M_AXI_ARVALID && !ar_hs) ? ar_cnt + 1 : 0;
      if (aw_hs) begin aw_have <= 1'b1; aw_addr_l <= axi.M_AXI_AWADDR; end
      if (w_hs) begin w_have <= 1'b1; w_data_l <= axi.M_AXI_WDATA; w_strb_l <= axi.M_AXI_WSTRB; end
      if (aw_full && w_full && !bvalid) begin
        for (int b = 0; b < SW; b++)
          if (ws[b]) mem[wa[AW-1:2]][8*b +: 8] <= wd[8*b +: 8];
        bvalid <= 1'b1; bresp <= cfg_bresp; aw_have <= 1'b0; w_have <= 1'b0;
      end else if (bvalid && axi.M_AXI_BREADY) bvalid <= 1'b0;
      if (ar_hs) begin rvalid <= 1'b1; rdata <= mem[axi.M_AXI_ARADDR[AW-1:2]]; end
      else if (rvalid && axi.M_AXI_RREADY) rvalid <= 1'b0;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic we; logic [DW-1:0] rdata; logic [1:0] resp; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] model [NW];

  logic          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;
  int            n_awv = 0, n_wv = 0, n_b = 0, n_rsp = 0;

  always @(negedge clk) begin
    if (rst) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
    end else begin
      // A VALID left unaccepted must still be high, with the same payload, one cycle later.
      if (p_aw) chk("aw_hold", 64'({axi.M_AXI_AWVALID, axi.M_AXI_AWADDR}), 64'({1'b1, p_awaddr}));
      if (p_w)  chk("w_hold", 64'({axi.M_AXI_WVALID, axi.M_AXI_WSTRB, axi.M_AXI_WDATA}),
                    64'({1'b1, p_wstrb, p_wdata}));
      if (p_ar) chk("ar_hold", 64'({axi.M_AXI_ARVALID, axi.M_AXI_ARADDR}), 64'({1'b1, p_araddr}));
      p_aw <= axi.M_AXI_AWVALID && !axi.M_AXI_AWREADY; p_awaddr <= axi.M_AXI_AWADDR;
      p_w  <= axi.M_AXI_WVALID && !axi.M_AXI_WREADY;   p_wdata <= axi.M_AXI_WDATA;
      p_wstrb <= axi.M_AXI_WSTRB;
      p_ar <= axi.M_AXI_ARVALID && !axi.M_AXI_ARREADY; p_araddr <= axi.M_AXI_ARADDR;
      n_awv <= n_awv + int'(axi.M_AXI_AWVALID);
      n_wv  <= n_wv + int'(axi.M_AXI_WVALID);
      n_b   <= n_b + int'(axi.M_AXI_BVALID && axi.M_AXI_BREADY);
      if (rsp_valid && rsp_ready) begin
        n_rsp <= n_rsp + 1;
        if (sb.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        else begin
          chk("rsp_we", 64'(rsp_we), 64'(sb[0].we));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(sb[0].rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(sb[0].resp));
          sb.delete(0);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NW; i++) model[i] = init_val(i);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic keep);
    exp_t e;
    bit   ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    chk("cmd_accept", 64'(ok), 64'(1));
    if (ok) begin
      chk("one_outstanding", 64'(sb.size()), 64'(0));
      e.we = we;
      e.resp = we ? cfg_bresp : 2'b00;
      if (we) begin
        for (int b = 0; b < SW; b++)
          if (s[b]) model[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
        e.rdata = '0;
      end else e.rdata = model[a[AW-1:2]];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("rsp_timeout", 64'(sb.size()), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, w0, b0, r0;
    bit seen;
    logic [4:0] ix;
    cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valids", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID,
                           axi.M_AXI_BREADY, axi.M_AXI_RREADY}), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'(0));
    chk("rst_bus", 64'({axi.M_AXI_AWADDR, axi.M_AXI_ARADDR, axi.M_AXI_WSTRB, axi.M_AXI_WDATA}), 64'(0));
    chk("prot", 64'({axi.M_AXI_AWPROT, axi.M_AXI_ARPROT}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

    // zero-wait write: VALIDs at +1, rsp_valid at +3; then read it back
    issue(1'b1, 7'h40, 32'h8000_0000, 4'b1000, 1'b0);
    @(negedge clk);
    chk("t1_awv_wv_c1", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID}), 64'(2'b11));
    chk("t1_cmd_ready_c1", 64'(cmd_ready), 64'(0));
    chk("t1_rsp_c1", 64'(rsp_valid), 64'(0));
    @(negedge clk); chk("t1_rsp_c2", 64'(rsp_valid), 64'(0));
    @(negedge clk); chk("t1_rsp_c3", 64'(rsp_valid), 64'(1));
    wait_rsp();
    issue(1'b0, 7'h40, '0, '0, 1'b0);
    wait_rsp();

    // WREADY three cycles late
    w_wait = 3;
    a0 = n_awv; w0 = n_wv; b0 = n_b; r0 = n_rsp;
    issue(1'b1, 7'h10, 32'h1234_5678, 4'hF, 1'b0);
    wait_rsp();
    chk("t2_awv_cycles", 64'(n_awv - a0), 64'(1));
    chk("t2_wv_cycles", 64'(n_wv - w0), 64'(4));
    chk("t2_b_count", 64'(n_b - b0), 64'(1));
    chk("t2_rsp_count", 64'(n_rsp - r0), 64'(1));
    w_wait = 0;

    // response back-pressure
    rsp_ready = 1'b0;
    issue(1'b0, 7'h44, '0, '0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("t3_rsp_seen", 64'(seen), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold", 64'({rsp_valid, cmd_ready, rsp_rdata}), 64'({1'b1, 1'b0, model[17]}));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp();

    // back-to-back with cmd_valid held
    issue(1'b1, 7'h08, 32'hDEAD_BEEF, 4'hF, 1'b1);
    issue(1'b0, 7'h08, '0, '0, 1'b0);
    wait_rsp();

    // SLVERR write response
    cfg_bresp = 2'b10;
    issue(1'b1, 7'h0C, 32'h0000_0055, 4'h1, 1'b0);
    wait_rsp();
    chk("t5_idle", 64'(cmd_ready), 64'(1));
    cfg_bresp = 2'b00;

    // reset in the middle of a write
    aw_wait = 20;
    issue(1'b1, 7'h20, 32'h0000_0001, 4'hF, 1'b0);
    @(negedge clk);
    chk("t6_awv_pre", 64'(axi.M_AXI_AWVALID), 64'(1));
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); @(negedge clk);
    chk("t6_valids", 64'({axi.M_AXI_AWVALID, axi.M_AXI_WVALID, axi.M_AXI_ARVALID}), 64'(0));
    chk("t6_rsp_cmd", 64'({rsp_valid, cmd_ready}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    aw_wait = 0;
    model_reset();
    @(posedge clk); @(negedge clk);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'(1));
    issue(1'b0, 7'h44, '0, '0, 1'b0);
    wait_rsp();

    // random mix with random slave delays
    for (int t = 0; t < 16; t++) begin
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); ar_wait = $urandom_range(0, 3);
      ix = 5'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), {ix, 2'b00}, $urandom, 4'($urandom_range(0, 15)), 1'b0);
      wait_rsp();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
